// File: rtl/sequence_generator_if.sv
// Bus bundle between the sequence generator and its consumer.
// The corrupt request exists only when SEQGEN_CORRUPT_EN is defined.
interface sequence_generator_if;
  logic       start;
  logic       abort;
`ifdef SEQGEN_CORRUPT_EN
  logic       corrupt;
`endif
  logic [2:0] data_out;
  logic       data_valid;
  logic       frame_last;
  logic       busy;
  logic       done;

  modport master (
`ifdef SEQGEN_CORRUPT_EN
    output corrupt,
`endif
    output start, abort,
    input  data_out, data_valid, frame_last, busy, done
  );

  modport slave (
`ifdef SEQGEN_CORRUPT_EN
    input  corrupt,
`endif
    input  start, abort,
    output data_out, data_valid, frame_last, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Sends bursts of the 8-term pattern 1,5,6,0,6,6,3,5 on a 3-bit bus with optional gaps.
// Define SEQGEN_CORRUPT_EN to add a per-frame request that turns term 7 into 3'b100.
module sequence_generator #(
  parameter int unsigned NUM_FRAMES = 1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [2:0]  IDLE_VALUE = 3'b111
) (
  input logic           clk,
  input logic           reset_n,
  sequence_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  // Term 0 sits in the least significant slice.
  localparam logic [23:0] TERMS       = {3'b101, 3'b011, 3'b110, 3'b110,
                                         3'b000, 3'b110, 3'b101, 3'b001};
  localparam logic [7:0]  FRAMES_INIT = 8'(NUM_FRAMES);
  localparam bit          HAS_GAP     = (GAP_CYCLES != 0);
  localparam logic [7:0]  GAP_LAST    = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic [2:0] term_rom [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_term_rom
      assign term_rom[gi] = TERMS[gi*3 +: 3];
    end
  endgenerate

  state_t     state_reg,       state_next;
  logic [2:0] term_idx_reg,    term_idx_next;
  logic [7:0] frames_left_reg, frames_left_next;
  logic [7:0] gap_cnt_reg,     gap_cnt_next;
  logic       start_pend_reg,  start_pend_next;
  logic       corrupt_reg,     corrupt_next;
  logic [2:0] data_out_reg,    data_out_next;
  logic       data_valid_reg,  data_valid_next;
  logic       frame_last_reg,  frame_last_next;
  logic       busy_reg,        busy_next;
  logic       done_reg,        done_next;
  logic       corrupt_in;

`ifdef SEQGEN_CORRUPT_EN
  assign corrupt_in = bus.corrupt;
`else
  assign corrupt_in = 1'b0;
`endif

  // A start captured in IDLE waits one cycle before term 0 is loaded.
  always_comb begin
    state_next       = state_reg;
    term_idx_next    = term_idx_reg;
    frames_left_next = frames_left_reg;
    gap_cnt_next     = gap_cnt_reg;
    corrupt_next     = corrupt_reg;
    start_pend_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_pend_reg) begin
          state_next       = SEND;
          term_idx_next    = 3'd0;
          frames_left_next = FRAMES_INIT;
          corrupt_next     = corrupt_in;
        end else begin
          start_pend_next = bus.start;
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (term_idx_reg == 3'd7) begin
          term_idx_next = 3'd0;
          if (frames_left_reg > 8'd1) begin
            frames_left_next = frames_left_reg - 8'd1;
            if (HAS_GAP) begin
              state_next   = GAP;
              gap_cnt_next = GAP_LAST;
            end else begin
              corrupt_next = corrupt_in;
            end
          end else begin
            state_next = DONE;
          end
        end else begin
          term_idx_next = term_idx_reg + 3'd1;
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (gap_cnt_reg == 8'd0) begin
          state_next    = SEND;
          term_idx_next = 3'd0;
          corrupt_next  = corrupt_in;
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they land in registers.
    data_valid_next = (state_next == SEND);
    frame_last_next = (state_next == SEND) && (term_idx_next == 3'd7);
    busy_next       = (state_next == SEND) || (state_next == GAP);
    done_next       = (state_next == DONE);
    data_out_next   = IDLE_VALUE;
    if (state_next == SEND) begin
      data_out_next = (frame_last_next && corrupt_next) ? 3'b100 : term_rom[term_idx_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      term_idx_reg    <= 3'd0;
      frames_left_reg <= 8'd0;
      gap_cnt_reg     <= 8'd0;
      start_pend_reg  <= 1'b0;
      corrupt_reg     <= 1'b0;
      data_out_reg    <= IDLE_VALUE;
      data_valid_reg  <= 1'b0;
      frame_last_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      term_idx_reg    <= term_idx_next;
      frames_left_reg <= frames_left_next;
      gap_cnt_reg     <= gap_cnt_next;
      start_pend_reg  <= start_pend_next;
      corrupt_reg     <= corrupt_next;
      data_out_reg    <= data_out_next;
      data_valid_reg  <= data_valid_next;
      frame_last_reg  <= frame_last_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.frame_last = frame_last_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench: three generator configurations share clock and reset; one is observed at a time.
// Iteration k of observe() is the k-th falling edge after start is driven, so term 0 shows at k=2.
module tb_sequence_generator;

  typedef struct packed {
    logic [2:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_drv = 1'b0;
  logic abort_drv = 1'b0;
  int   sel = 0;

  always #5 clk = ~clk;

  sequence_generator_if ifa ();
  sequence_generator_if ifb ();
  sequence_generator_if ifc ();

  assign ifa.start = start_drv && (sel == 0);
  assign ifb.start = start_drv && (sel == 1);
  assign ifc.start = start_drv && (sel == 2);
  assign ifa.abort = abort_drv && (sel == 0);
  assign ifb.abort = abort_drv && (sel == 1);
  assign ifc.abort = abort_drv && (sel == 2);

`ifdef SEQGEN_CORRUPT_EN
  logic        corrupt_drv = 1'b0;
  logic [63:0] corrupt_mask = 64'd0;
  assign ifa.corrupt = corrupt_drv;
  assign ifb.corrupt = corrupt_drv;
  assign ifc.corrupt = corrupt_drv;
`endif

  sequence_generator #(.NUM_FRAMES(1), .GAP_CYCLES(0), .IDLE_VALUE(3'b111)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  sequence_generator #(.NUM_FRAMES(3), .GAP_CYCLES(2), .IDLE_VALUE(3'b111)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));
  sequence_generator #(.NUM_FRAMES(2), .GAP_CYCLES(0), .IDLE_VALUE(3'b111)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(ifc));

  logic [2:0] obs_data;
  logic       obs_valid, obs_last, obs_busy, obs_done;

  always_comb begin
    obs_data  = ifa.data_out;
    obs_valid = ifa.data_valid;
    obs_last  = ifa.frame_last;
    obs_busy  = ifa.busy;
    obs_done  = ifa.done;
    if (sel == 1) begin
      obs_data  = ifb.data_out;
      obs_valid = ifb.data_valid;
      obs_last  = ifb.frame_last;
      obs_busy  = ifb.busy;
      obs_done  = ifb.done;
    end else if (sel == 2) begin
      obs_data  = ifc.data_out;
      obs_valid = ifc.data_valid;
      obs_last  = ifc.frame_last;
      obs_busy  = ifc.busy;
      obs_done  = ifc.done;
    end
  end

  // Reference detector: fires when the last eight valid terms form the pattern.
  localparam logic [23:0] PATTERN = 24'b001_101_110_000_110_110_011_101;
  logic [23:0] det_hist = 24'd0;
  int          det_fires = 0;

  always @(negedge clk) begin
    if (obs_valid === 1'b1) begin
      det_hist <= {det_hist[20:0], obs_data};
      if ({det_hist[20:0], obs_data} == PATTERN) det_fires <= det_fires + 1;
    end
  end

  exp_t       exp_q[$];
  logic [2:0] terms [8] = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5};
  int n_checks = 0;
  int n_fail = 0;
  int busy_cnt, done_cnt, done_iter, valid_cnt, first_valid, last_valid, gap_idle;

  task automatic push_frame(input bit corrupt);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = (i == 7 && corrupt) ? 3'b100 : terms[i];
      e.last = (i == 7);
      exp_q.push_back(e);
    end
  endtask

  // Drives the masked inputs per iteration and scoreboards every observed cycle.
  task automatic observe(input int n, input logic [63:0] smask, input logic [63:0] amask,
                         input logic [63:0] rmask);
    exp_t e;
    busy_cnt = 0; done_cnt = 0; done_iter = 0; valid_cnt = 0;
    first_valid = 0; last_valid = 0; gap_idle = 0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if (obs_valid === 1'b1) begin
          valid_cnt++;
          if (first_valid == 0) first_valid = c;
          last_valid = c;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_term: iter %0d data_out=%0d, required no valid term", c, obs_data);
          end else begin
            e = exp_q.pop_front();
            if (obs_data !== e.data || obs_last !== e.last) begin
              n_fail++;
              $display("FAIL term: iter %0d data_out=%0d frame_last=%0d, required %0d/%0d",
                       c, obs_data, obs_last, e.data, e.last);
            end
          end
        end else if (obs_data !== 3'b111 || obs_last !== 1'b0 || obs_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_bus: iter %0d data_out=%0d valid=%0d last=%0d, required 7/0/0",
                   c, obs_data, obs_valid, obs_last);
        end
        if (obs_busy === 1'b1) busy_cnt++;
        if (obs_busy === 1'b1 && obs_valid !== 1'b1) gap_idle++;
        if (obs_done === 1'b1) begin
          done_cnt++;
          if (done_iter == 0) done_iter = c;
          n_checks++;
          if (obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_busy: iter %0d busy=%0d, required 0", c, obs_busy);
          end
        end
      end
      start_drv = smask[c];
      abort_drv = amask[c];
      reset_n   = !rmask[c];
`ifdef SEQGEN_CORRUPT_EN
      corrupt_drv = corrupt_mask[c];
`endif
    end
    start_drv = 1'b0;
    abort_drv = 1'b0;
    reset_n   = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_terms: %0d terms never seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (obs_data !== 3'b111 || obs_valid !== 1'b0 || obs_last !== 1'b0 ||
          obs_busy !== 1'b0 || obs_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: dut %0d data=%0d valid=%0d last=%0d busy=%0d done=%0d, required 7/0/0/0/0",
                 s, obs_data, obs_valid, obs_last, obs_busy, obs_done);
      end
    end
    reset_n = 1'b1;
    $display("test_reset: idle outputs checked on 3 instances");
  endtask

  task automatic test_single();
    int det0;
    sel = 0;
    push_frame(1'b0);
    det0 = det_fires;
    observe(14, 64'd1, 64'd0, 64'd0);
    n_checks++;
    if (first_valid != 2 || last_valid != 9 || valid_cnt != 8) begin
      n_fail++;
      $display("FAIL single_window: valid %0d..%0d count %0d, required 2..9 count 8",
               first_valid, last_valid, valid_cnt);
    end
    n_checks++;
    if (busy_cnt != 8 || done_cnt != 1 || done_iter != 10) begin
      n_fail++;
      $display("FAIL single_busy_done: busy %0d done %0d at %0d, required 8/1/10",
               busy_cnt, done_cnt, done_iter);
    end
    n_checks++;
    if (det_fires - det0 != 1) begin
      n_fail++;
      $display("FAIL single_detect: fires %0d, required 1", det_fires - det0);
    end
    $display("test_single: valid=%0d busy=%0d done_iter=%0d", valid_cnt, busy_cnt, done_iter);
  endtask

  task automatic test_gapped();
    sel = 1;
    repeat (3) push_frame(1'b0);
    observe(34, 64'd1, 64'd0, 64'd0);
    n_checks++;
    if (valid_cnt != 24 || gap_idle != 4 || busy_cnt != 28) begin
      n_fail++;
      $display("FAIL gapped_counts: valid %0d gap %0d busy %0d, required 24/4/28",
               valid_cnt, gap_idle, busy_cnt);
    end
    n_checks++;
    if (done_cnt != 1 || done_iter != 30 || first_valid != 2 || last_valid != 29) begin
      n_fail++;
      $display("FAIL gapped_timing: done %0d at %0d valid %0d..%0d, required 1 at 30, 2..29",
               done_cnt, done_iter, first_valid, last_valid);
    end
    $display("test_gapped: valid=%0d gap=%0d busy=%0d", valid_cnt, gap_idle, busy_cnt);
  endtask

  task automatic test_back_to_back();
    sel = 2;
    repeat (2) push_frame(1'b0);
    observe(22, 64'd1, 64'd0, 64'd0);
    n_checks++;
    if (valid_cnt != 16 || first_valid != 2 || last_valid != 17 || gap_idle != 0) begin
      n_fail++;
      $display("FAIL b2b_window: valid %0d at %0d..%0d gap %0d, required 16 at 2..17 gap 0",
               valid_cnt, first_valid, last_valid, gap_idle);
    end
    n_checks++;
    if (busy_cnt != 16 || done_cnt != 1 || done_iter != 18) begin
      n_fail++;
      $display("FAIL b2b_done: busy %0d done %0d at %0d, required 16/1/18",
               busy_cnt, done_cnt, done_iter);
    end
    $display("test_back_to_back: valid=%0d busy=%0d done_iter=%0d", valid_cnt, busy_cnt, done_iter);
  endtask

  task automatic test_abort();
    sel = 1;
    push_frame(1'b0);
    repeat (3) void'(exp_q.pop_back());
    observe(20, 64'd1, 64'd1 << 6, 64'd0);
    n_checks++;
    if (valid_cnt != 5 || busy_cnt != 5 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort: valid %0d busy %0d done %0d, required 5/5/0", valid_cnt, busy_cnt, done_cnt);
    end
    repeat (3) push_frame(1'b0);
    observe(34, 64'd1, 64'd0, 64'd0);
    n_checks++;
    if (busy_cnt != 28 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL abort_restart: busy %0d done %0d, required 28/1", busy_cnt, done_cnt);
    end
    $display("test_abort: restart busy=%0d done=%0d", busy_cnt, done_cnt);
  endtask

  task automatic test_reset_in_gap();
    sel = 1;
    push_frame(1'b0);
    observe(20, 64'd1, 64'd0, 64'd1 << 10);
    n_checks++;
    if (valid_cnt != 8 || busy_cnt != 9 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL gap_reset: valid %0d busy %0d done %0d, required 8/9/0", valid_cnt, busy_cnt, done_cnt);
    end
    repeat (3) push_frame(1'b0);
    observe(34, 64'd1, 64'd0, 64'd0);
    n_checks++;
    if (busy_cnt != 28 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL gap_reset_restart: busy %0d done %0d, required 28/1", busy_cnt, done_cnt);
    end
    $display("test_reset_in_gap: restart busy=%0d done=%0d", busy_cnt, done_cnt);
  endtask

  task automatic test_repulse();
    sel = 0;
    push_frame(1'b0);
    observe(16, 64'd1 | (64'd1 << 4) | (64'd1 << 10), 64'd0, 64'd0);
    n_checks++;
    if (valid_cnt != 8 || busy_cnt != 8 || done_cnt != 1 || done_iter != 10) begin
      n_fail++;
      $display("FAIL repulse: valid %0d busy %0d done %0d at %0d, required 8/8/1 at 10",
               valid_cnt, busy_cnt, done_cnt, done_iter);
    end
    $display("test_repulse: valid=%0d busy=%0d", valid_cnt, busy_cnt);
  endtask

  task automatic test_start_abort();
    sel = 0;
    push_frame(1'b0);
    observe(14, 64'd1, 64'd3, 64'd0);
    n_checks++;
    if (valid_cnt != 8 || first_valid != 2 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL start_abort: valid %0d first %0d done %0d, required 8/2/1",
               valid_cnt, first_valid, done_cnt);
    end
    $display("test_start_abort: valid=%0d done=%0d", valid_cnt, done_cnt);
  endtask

`ifdef SEQGEN_CORRUPT_EN
  task automatic test_corrupt();
    int det0;
    sel = 2;
    push_frame(1'b1);
    push_frame(1'b0);
    corrupt_mask = 64'd1 << 1;
    det0 = det_fires;
    observe(22, 64'd1, 64'd0, 64'd0);
    corrupt_mask = 64'd0;
    n_checks++;
    if (valid_cnt != 16 || det_fires - det0 != 1) begin
      n_fail++;
      $display("FAIL corrupt: valid %0d fires %0d, required 16/1", valid_cnt, det_fires - det0);
    end
    $display("test_corrupt: detector fires=%0d", det_fires - det0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_back_to_back();
    test_abort();
    test_reset_in_gap();
    test_repulse();
    test_start_abort();
`ifdef SEQGEN_CORRUPT_EN
    test_corrupt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Transmit-side counterpart of the team's 3-bit sequence detector. On a start request it drives the 8-term pattern 001, 101, 110, 000, 110, 110, 011, 101 onto a 3-bit bus, one term per clock. It can send a programmable number of back-to-back or gapped frames. Used as a stimulus source and link-check transmitter feeding a detector on the same clock.

Parameters:
NUM_FRAMES, 1, frames sent per start request; legal range 1..255.
GAP_CYCLES, 0, idle cycles inserted between consecutive frames of one burst; legal range 0..255.
IDLE_VALUE, 3'b111, value driven on data_out whenever no term is being sent.

Ports:
clk  input  1  single system clock; all logic on the rising edge.
reset_n  input  1  synchronous, active-low reset.
start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
abort  input  1  synchronous cancel of a burst in progress.
data_out  output  3  current sequence term, or IDLE_VALUE.
data_valid  output  1  high exactly when data_out carries a sequence term.
frame_last  output  1  high coincident with term 7 (101) of every frame.
busy  output  1  high from the cycle after start is accepted until the burst ends.
done  output  1  one-cycle pulse after the final frame completes normally.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at a rising edge): state=IDLE; data_out=IDLE_VALUE; data_valid=0; frame_last=0; busy=0; done=0; all counters cleared.
- Reset applied mid-burst takes effect at that edge. No done pulse is generated.
- States:
  - IDLE: start=1 -> SEND, term_idx=0, frames_left=NUM_FRAMES.
  - SEND: drives term[term_idx] with data_valid=1. term_idx increments each cycle.
  - GAP: drives IDLE_VALUE with data_valid=0 for exactly GAP_CYCLES cycles, then returns to SEND at term 0.
  - DONE: one cycle; done=1, busy=0, data_valid=0. Then -> IDLE.
- Latency: start sampled high at edge N -> term 0 visible after edge N+1.
- Terms then appear on 8 consecutive cycles with no bubbles inside a frame.
- After term 7:
  - frames_left>1 and GAP_CYCLES>0 -> GAP.
  - frames_left>1 and GAP_CYCLES=0 -> term 0 of the next frame on the very next cycle.
  - frames_left=1 -> DONE.
- term_idx wraps 7 -> 0 at each frame boundary. frames_left decrements once per completed frame.
- Burst length in cycles: 8*NUM_FRAMES + GAP_CYCLES*(NUM_FRAMES-1), then 1 DONE cycle.
- start while busy or in DONE is ignored; it is not queued.
- abort=1 in SEND or GAP: next cycle IDLE, data_out=IDLE_VALUE, data_valid=0, busy=0, no done pulse.
- abort in IDLE or DONE has no effect.
- start and abort both high in IDLE: start wins, abort ignored.
- busy is high in SEND and GAP only.

Optional Feature:
Macro: SEQGEN_CORRUPT_EN.
- When defined, adds input port corrupt (1 bit).
  - corrupt is sampled at the edge that loads term 0 of a frame.
  - If high, term 7 of that frame is driven as 3'b100 (101 XOR 001) instead of 101. All other terms are unchanged.
  - frame_last and data_valid timing are unchanged.
  - Intended for detector negative tests.
- When undefined: no corrupt port, and term 7 is always 101.

Test Plan:
- Reset, then start pulse with NUM_FRAMES=1, GAP_CYCLES=0 -> on cycles 1..8 after start, data_out=1,5,6,0,6,6,3,5 with data_valid=1; frame_last=1 only on cycle 8; done=1 on cycle 9; busy=1 on cycles 1..8.
- NUM_FRAMES=3, GAP_CYCLES=2 -> 3 frames; exactly 2 cycles of data_out=3'b111, data_valid=0 between frames; total busy=28 cycles; a single done pulse.
- NUM_FRAMES=2, GAP_CYCLES=0 -> 16 consecutive valid terms, with term 7 (5) immediately followed by term 0 (1); frame_last high on cycles 8 and 16.
- abort asserted during term 4, and separately reset_n=0 during GAP -> idle outputs on the next cycle, no done pulse; a new start is accepted afterwards.
- start re-pulsed while busy, and start+abort together in IDLE -> the re-pulse is ignored (burst length unchanged); the simultaneous case starts a burst.
- With SEQGEN_CORRUPT_EN defined, corrupt=1 at term-0 load -> term 7 = 3'b100; a detector on the bus does not fire. Next frame with corrupt=0 -> 101, and the detector fires.
